ndma_obi_sub_mem: RTL and testbench
===================================

NDMA_OBI_SUB_MEM -- requirements
Module: ndma_obi_sub_mem

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 16, meaning the number of 32-bit storage words (power of two, 2..256).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0 (aligned to 4*NUM_WORDS).
REQ-003 SHALL have parameter GNT_DELAY, default 0, meaning the number of cycles req is held before gnt (0..7).
REQ-004 SHALL have parameter RESP_DELAY, default 1, meaning the number of cycles from grant to rvalid (1..4).
REQ-005 SHALL have port clk_i  input  1  sole clock; all logic on the rising edge.
REQ-006 SHALL have port rst_i  input  1  reset; synchronous and active-high.
REQ-007 SHALL have port obi_sub  interface  OBI_BUS.Subordinate  OBI responder port, using req, addr[31:0], we, be[3:0], wdata[31:0] (in) and gnt, rvalid, rdata[31:0], err (out).
REQ-008 SHALL have port busy_o  output  1  high while any granted transaction has not yet returned rvalid.
REQ-009 SHALL have port err_cnt_o  output  8  count of responses returned with err=1; saturates at 8'hFF.

Function
REQ-010 SHALL treat a transaction as accepted in every cycle where req=1 and gnt=1; addr, we, be and wdata are sampled in that cycle only.
REQ-011 SHALL decode addresses as in range when BASE_ADDR <= addr < BASE_ADDR+4*NUM_WORDS; word index = (addr-BASE_ADDR)>>2; addr[1:0] is ignored.
REQ-012 SHALL implement grant FSM states IDLE and WAIT; the FSM resets to IDLE.
REQ-013 With GNT_DELAY=0, SHALL assert gnt combinationally with req in IDLE (zero-wait, back-to-back grants allowed every cycle).
REQ-014 With GNT_DELAY=N>0: IDLE with req=1 -> WAIT, wait counter=1; WAIT increments counter each cycle req=1; gnt=1 when counter==N; after gnt -> IDLE, counter=0.
REQ-015 SHALL return WAIT -> IDLE and clear the counter if req drops before gnt; no transaction occurs.
REQ-016 SHALL never assert gnt when req=0.
REQ-017 In-range write: at the grant edge, SHALL update each byte lane i where be[i]=1 with wdata[8i+7:8i]; lanes with be[i]=0 keep their value; be=4'h0 changes nothing and responds with err=0.
REQ-018 In-range read: SHALL capture the full stored word in the grant cycle, regardless of be, for return as rdata.
REQ-019 Out-of-range access: SHALL be granted normally, SHALL NOT modify storage, and SHALL respond with err=1 and rdata=0.
REQ-020 Write responses SHALL carry rdata=0.
REQ-021 SHALL assert rvalid for exactly one cycle, exactly RESP_DELAY cycles after each grant edge, with matching rdata and err.
REQ-022 SHALL return responses in grant order with no rready back-pressure; up to RESP_DELAY responses may be in flight; the response pipeline never stalls.
REQ-023 A read granted the cycle after a write to the same word SHALL return the newly written data.
REQ-024 When rvalid=0, SHALL drive rdata=0 and err=0.
REQ-025 busy_o SHALL be 1 from the cycle after a grant until the cycle its rvalid is asserted, inclusive, while any response is in flight.
REQ-026 err_cnt_o SHALL increment by 1 on each rvalid with err=1 and SHALL hold at 8'hFF.

Reset
REQ-027 While rst_i=1 at a clock edge, SHALL set the FSM to IDLE, wait counter=0, all storage words=32'h0, response pipeline empty, and err_cnt_o=0.
REQ-028 After reset: gnt=0 (unless GNT_DELAY=0 and req=1), rvalid=0, rdata=0, err=0, busy_o=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight responses; no rvalid for a pre-reset grant appears after reset is released.
REQ-030 Reset SHALL take priority over a simultaneous req/gnt, and the concurrent write SHALL have no effect.

Verification
REQ-031 Defaults: write addr 0x8, wdata 0xDEADBEEF, be 0xF, then read 0x8 in the next cycle -> both granted in the same cycle as req; read rvalid two cycles after the write, rdata 0xDEADBEEF, err 0.
REQ-032 Byte lanes: word 0x4 holds 0x11223344; write 0xAABBCCDD with be 0x5 -> subsequent read of 0x4 returns 0x11BB33DD.
REQ-033 Out of range: NUM_WORDS=16, read 0x40 -> gnt, rvalid err=1, rdata 0, err_cnt_o=1; a write to 0x40 leaves all words unchanged.
REQ-034 GNT_DELAY=3: req held -> gnt on the third req cycle; req dropped after 2 cycles -> no gnt, FSM back in IDLE, no rvalid.
REQ-035 RESP_DELAY=4, four back-to-back reads of 0x0..0xC -> four consecutive rvalid cycles in order, the first 4 cycles after the first grant; busy_o high throughout.
REQ-036 Reset pulse 2 cycles after a grant with RESP_DELAY=4 -> no rvalid afterwards, busy_o=0, err_cnt_o=0, read of the previously written word returns 0.

Source files
------------

// File: rtl/ndma_obi_sub_mem_if.sv
`timescale 1ns/1ps
// OBI request/response signal bundle shared by managers and subordinates.
interface OBI_BUS;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport Manager (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
  modport Subordinate (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/ndma_obi_sub_mem.sv
`timescale 1ns/1ps
// OBI subordinate backed by a byte-writable word memory, with configurable
// grant wait-states and a fixed-latency, never-stalling response pipeline.
module ndma_obi_sub_mem #(
  parameter int          NUM_WORDS  = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          GNT_DELAY  = 0,
  parameter int          RESP_DELAY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  OBI_BUS.Subordinate obi_sub,
  output logic        busy_o,
  output logic [7:0]  err_cnt_o
);
  localparam int          IDX_W = $clog2(NUM_WORDS);
  localparam logic [31:0] SPAN  = 32'(4 * NUM_WORDS);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, held;
  logic        gnt;

  logic [31:0] offset;
  logic        in_range;
  logic [IDX_W-1:0] idx;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem [NUM_WORDS];

  logic [RESP_DELAY-1:0] vld_p;
  logic [RESP_DELAY-1:0] err_p;
  logic [31:0]           rdata_p [RESP_DELAY];
  logic [7:0]            err_cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // held counts the current cycle too, so the grant lands on the GNT_DELAY-th req cycle
  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    held    = (state_q == WAIT) ? cnt_q + 3'd1 : 3'd1;
    gnt     = obi_sub.req && ((GNT_DELAY == 0) || (held == 3'(GNT_DELAY)));
    if (obi_sub.req && !gnt) begin
      state_d = WAIT;
      cnt_d   = held;
    end
  end

  assign obi_sub.gnt = gnt;

  // Subtract-then-compare also rejects addresses below BASE_ADDR via wrap-around.
  assign offset     = obi_sub.addr - BASE_ADDR;
  assign in_range   = offset < SPAN;
  assign idx        = offset[IDX_W+1:2];
  assign resp_err   = !in_range;
  assign resp_rdata = (in_range && !obi_sub.we) ? mem[idx] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < NUM_WORDS; w++) mem[w] <= '0;
    end else if (gnt && obi_sub.we && in_range) begin
      for (int b = 0; b < 4; b++)
        if (obi_sub.be[b]) mem[idx][8*b +: 8] <= obi_sub.wdata[8*b +: 8];
    end
  end

  // Stage p0 captures the response at the grant edge; later stages only delay it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= gnt;
      for (int s = 1; s < RESP_DELAY; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    rdata_p[0] <= resp_rdata;
    err_p[0]   <= resp_err;
    for (int s = 1; s < RESP_DELAY; s++) begin
      rdata_p[s] <= rdata_p[s-1];
      err_p[s]   <= err_p[s-1];
    end
  end

  assign obi_sub.rvalid = vld_p[RESP_DELAY-1];
  assign obi_sub.rdata  = vld_p[RESP_DELAY-1] ? rdata_p[RESP_DELAY-1] : '0;
  assign obi_sub.err    = vld_p[RESP_DELAY-1] & err_p[RESP_DELAY-1];
  assign busy_o         = |vld_p;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt <= '0;
    end else if (obi_sub.rvalid && obi_sub.err) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end

  assign err_cnt_o = err_cnt;
endmodule

// File: tb/tb_ndma_obi_sub_mem.sv
`timescale 1ns/1ps
// Bench for ndma_obi_sub_mem: three instances (defaults, GNT_DELAY=3, RESP_DELAY=4)
// checked each cycle against a due-cycle scoreboard model plus literal spot checks.
module tb_ndma_obi_sub_mem;
  localparam int GD [3] = '{0, 3, 0};
  localparam int RD [3] = '{1, 1, 4};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_s   [3];
  logic [31:0] addr_s  [3];
  logic        we_s    [3];
  logic [3:0]  be_s    [3];
  logic [31:0] wdata_s [3];
  logic        gnt_s   [3];
  logic        rvalid_s[3];
  logic [31:0] rdata_s [3];
  logic        err_s   [3];
  logic        busy_s  [3];
  logic [7:0]  ecnt_s  [3];

  for (genvar i = 0; i < 3; i++) begin : g_dut
    OBI_BUS bus ();
    assign bus.req      = req_s[i];
    assign bus.addr     = addr_s[i];
    assign bus.we       = we_s[i];
    assign bus.be       = be_s[i];
    assign bus.wdata    = wdata_s[i];
    assign gnt_s[i]     = bus.gnt;
    assign rvalid_s[i]  = bus.rvalid;
    assign rdata_s[i]   = bus.rdata;
    assign err_s[i]     = bus.err;
    ndma_obi_sub_mem #(
      .NUM_WORDS (16),
      .BASE_ADDR (32'h0000_0000),
      .GNT_DELAY ((i == 1) ? 3 : 0),
      .RESP_DELAY((i == 2) ? 4 : 1)
    ) u_dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .obi_sub  (bus.Subordinate),
      .busy_o   (busy_s[i]),
      .err_cnt_o(ecnt_s[i])
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", nm, k, $time, act, exp);
    end
  endtask

  // Model: memory image, consecutive-req run length, and responses keyed by due cycle.
  logic [31:0] mm [3][16];
  int          run [3];
  logic        pv [3][8];
  logic [31:0] pd [3][8];
  logic        pe [3][8];
  int          ec [3];
  int          cyc = 0;

  function automatic logic exp_gnt(input int k);
    return req_s[k] && ((GD[k] == 0) || (run[k] + 1 == GD[k]));
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int w = 0; w < 16; w++) mm[k][w] = '0;
        for (int s = 0; s < 8; s++) pv[k][s] = 1'b0;
        run[k] = 0;
        ec[k]  = 0;
      end else begin
        logic        g;
        logic [31:0] d;
        logic        e;
        int          w;
        g = exp_gnt(k);
        if (pv[k][cyc % 8]) begin
          if (pe[k][cyc % 8] && ec[k] < 255) ec[k]++;
          pv[k][cyc % 8] = 1'b0;
        end
        if (g) begin
          d = '0;
          e = 1'b0;
          if (addr_s[k] >= 32'd64) begin
            e = 1'b1;
          end else begin
            w = int'(addr_s[k][5:2]);
            if (we_s[k]) begin
              for (int b = 0; b < 4; b++)
                if (be_s[k][b]) mm[k][w][8*b +: 8] = wdata_s[k][8*b +: 8];
            end else begin
              d = mm[k][w];
            end
          end
          pv[k][(cyc + RD[k]) % 8] = 1'b1;
          pd[k][(cyc + RD[k]) % 8] = d;
          pe[k][(cyc + RD[k]) % 8] = e;
          run[k] = 0;
        end else begin
          run[k] = req_s[k] ? run[k] + 1 : 0;
        end
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic rv;
      logic anyb;
      rv   = pv[k][cyc % 8];
      anyb = 1'b0;
      for (int s = 0; s < 8; s++) anyb |= pv[k][s];
      chk("gnt",     k, 32'(gnt_s[k]),    32'(exp_gnt(k)));
      chk("rvalid",  k, 32'(rvalid_s[k]), 32'(rv));
      chk("rdata",   k, rdata_s[k],       rv ? pd[k][cyc % 8] : 32'h0);
      chk("err",     k, 32'(err_s[k]),    rv ? 32'(pe[k][cyc % 8]) : 32'h0);
      chk("busy",    k, 32'(busy_s[k]),   32'(anyb));
      chk("err_cnt", k, 32'(ecnt_s[k]),   32'(ec[k]));
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
    end
  end

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      req_s[k]   = 1'b0;
      addr_s[k]  = '0;
      we_s[k]    = 1'b0;
      be_s[k]    = '0;
      wdata_s[k] = '0;
    end
  endtask

  task automatic drv(input int k, input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    req_s[k]   = 1'b1;
    we_s[k]    = w;
    addr_s[k]  = a;
    be_s[k]    = b;
    wdata_s[k] = d;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
    idle_all();
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    repeat (3) go();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_rvalid", k, 32'(rvalid_s[k]), 32'h0);
      chk("rst_busy",   k, 32'(busy_s[k]),   32'h0);
      chk("rst_errcnt", k, 32'(ecnt_s[k]),   32'h0);
      chk("rst_gnt",    k, 32'(gnt_s[k]),    32'h0);
    end

    // Defaults: zero-wait write then read of the same word.
    go(); drv(0, 1'b1, 32'h8, 4'hF, 32'hDEADBEEF); #1;
    chk("t1_wr_gnt", 0, 32'(gnt_s[0]), 32'h1);
    go(); drv(0, 1'b0, 32'h8, 4'hF, 32'h0); #1;
    chk("t1_rd_gnt", 0, 32'(gnt_s[0]), 32'h1);
    chk("t1_wr_rsp", 0, 32'(rvalid_s[0]), 32'h1);
    chk("t1_wr_rdata", 0, rdata_s[0], 32'h0);
    go(); #1;
    chk("t1_rd_rvalid", 0, 32'(rvalid_s[0]), 32'h1);
    chk("t1_rd_rdata", 0, rdata_s[0], 32'hDEADBEEF);
    chk("t1_rd_err", 0, 32'(err_s[0]), 32'h0);

    // Byte lanes, be=0 write, and ignored addr[1:0].
    go(); drv(0, 1'b1, 32'h4, 4'hF, 32'h11223344);
    go(); drv(0, 1'b1, 32'h4, 4'h5, 32'hAABBCCDD);
    go(); drv(0, 1'b1, 32'h4, 4'h0, 32'hFFFFFFFF);
    go(); drv(0, 1'b0, 32'h7, 4'h0, 32'h0);
    go(); #1;
    chk("t2_lanes", 0, rdata_s[0], 32'h11BB33DD);

    // Out of range accesses.
    go(); drv(0, 1'b0, 32'h40, 4'hF, 32'h0);
    go(); #1;
    chk("t3_oor_rvalid", 0, 32'(rvalid_s[0]), 32'h1);
    chk("t3_oor_err", 0, 32'(err_s[0]), 32'h1);
    chk("t3_oor_rdata", 0, rdata_s[0], 32'h0);
    go(); #1;
    chk("t3_errcnt1", 0, 32'(ecnt_s[0]), 32'h1);
    drv(0, 1'b1, 32'h40, 4'hF, 32'hFFFFFFFF);
    go(); drv(0, 1'b1, 32'hFFFFFFFC, 4'hF, 32'hFFFFFFFF);
    for (int w = 0; w < 16; w++) begin
      go(); drv(0, 1'b0, 32'(w * 4), 4'hF, 32'h0);
    end
    go(); go(); #1;
    chk("t3_errcnt3", 0, 32'(ecnt_s[0]), 32'h3);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      go(); drv(0, 1'b0, 32'h80, 4'hF, 32'h0);
    end
    go(); go(); go(); #1;
    chk("t3_errcnt_sat", 0, 32'(ecnt_s[0]), 32'hFF);

    // GNT_DELAY=3: grant on third held cycle; abandoned request.
    go(); drv(1, 1'b0, 32'h0, 4'hF, 32'h0); #1;
    chk("t4_c1", 1, 32'(gnt_s[1]), 32'h0);
    go(); drv(1, 1'b0, 32'h0, 4'hF, 32'h0); #1;
    chk("t4_c2", 1, 32'(gnt_s[1]), 32'h0);
    go(); drv(1, 1'b0, 32'h0, 4'hF, 32'h0); #1;
    chk("t4_c3", 1, 32'(gnt_s[1]), 32'h1);
    go(); #1;
    chk("t4_rvalid", 1, 32'(rvalid_s[1]), 32'h1);
    go(); drv(1, 1'b1, 32'h10, 4'hF, 32'hCAFEF00D);
    go(); drv(1, 1'b1, 32'h10, 4'hF, 32'hCAFEF00D); #1;
    chk("t4_drop_c2", 1, 32'(gnt_s[1]), 32'h0);
    go(); go(); #1;
    chk("t4_drop_rvalid", 1, 32'(rvalid_s[1]), 32'h0);
    chk("t4_drop_busy", 1, 32'(busy_s[1]), 32'h0);
    go(); drv(1, 1'b1, 32'h10, 4'hF, 32'hCAFEF00D);
    go(); drv(1, 1'b1, 32'h10, 4'hF, 32'hCAFEF00D);
    go(); drv(1, 1'b1, 32'h10, 4'hF, 32'hCAFEF00D); #1;
    chk("t4_wr_gnt", 1, 32'(gnt_s[1]), 32'h1);
    go(); drv(1, 1'b0, 32'h10, 4'hF, 32'h0); #1;
    chk("t4_restart", 1, 32'(gnt_s[1]), 32'h0);
    go(); drv(1, 1'b0, 32'h10, 4'hF, 32'h0);
    go(); drv(1, 1'b0, 32'h10, 4'hF, 32'h0);
    go(); #1;
    chk("t4_rd_rdata", 1, rdata_s[1], 32'hCAFEF00D);

    // RESP_DELAY=4: back-to-back reads stream out in order.
    for (int w = 0; w < 4; w++) begin
      go(); drv(2, 1'b1, 32'(w * 4), 4'hF, 32'h1000_0000 + 32'(w));
    end
    for (int w = 0; w < 4; w++) begin
      go(); drv(2, 1'b0, 32'(w * 4), 4'hF, 32'h0);
    end
    for (int w = 0; w < 4; w++) begin
      go(); #1;
      chk("t5_rvalid", 2, 32'(rvalid_s[2]), 32'h1);
      chk("t5_rdata", 2, rdata_s[2], 32'h1000_0000 + 32'(w));
      chk("t5_busy", 2, 32'(busy_s[2]), 32'h1);
    end

    // Reset two cycles after a grant, with a concurrent write on dut0.
    go(); drv(2, 1'b1, 32'h14, 4'hF, 32'h55AA55AA);
    go();
    go(); rst = 1'b1; drv(0, 1'b1, 32'h4, 4'hF, 32'hFFFFFFFF);
    go(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_no_rvalid", 2, 32'(rvalid_s[2]), 32'h0);
      chk("t6_busy", 2, 32'(busy_s[2]), 32'h0);
      go();
    end
    chk("t6_errcnt", 0, 32'(ecnt_s[0]), 32'h0);
    drv(2, 1'b0, 32'h14, 4'hF, 32'h0);
    drv(0, 1'b0, 32'h4, 4'hF, 32'h0);
    go(); #1;
    chk("t6_rd0_rvalid", 0, 32'(rvalid_s[0]), 32'h1);
    chk("t6_rd0_rdata", 0, rdata_s[0], 32'h0);
    go(); go(); go(); #1;
    chk("t6_rd2_rvalid", 2, 32'(rvalid_s[2]), 32'h1);
    chk("t6_rd2_rdata", 2, rdata_s[2], 32'h0);

    go(); go(); go();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
